// File: rtl/fu_alu_arbiter.sv
// rtl/fu_alu_arbiter.sv - round-robin arbiter sharing one fu_alu between two requesters
module fu_alu_arbiter #(
  parameter int WORD_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_port_a,
  input  logic [WORD_W-1:0] req0_port_b,
  input  logic [3:0]        req0_aluop,
  input  logic [TAG_W-1:0]  req0_rd,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_port_a,
  input  logic [WORD_W-1:0] req1_port_b,
  input  logic [3:0]        req1_aluop,
  input  logic [TAG_W-1:0]  req1_rd,
  output logic [WORD_W-1:0] alu_port_a,
  output logic [WORD_W-1:0] alu_port_b,
  output logic [3:0]        alu_aluop,
  input  logic [WORD_W-1:0] alu_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [WORD_W-1:0] wb_result,
  output logic [TAG_W-1:0]  wb_rd,
  output logic              wb_src,
  output logic              wb_illegal,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  // rr_ptr names the requester that wins when both are valid
  logic rr_ptr;
  logic grant0;
  logic grant1;
  logic can_accept;
  logic acc0;
  logic acc1;
  logic op_illegal;

  // Codes 8, 9 and 12-15 have no ALU function behind them
  function automatic logic is_illegal(input logic [3:0] op);
    case (op)
      4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15: is_illegal = 1'b1;
      default:                                is_illegal = 1'b0;
    endcase
  endfunction

  // Grant selection, handshake and ALU operand steering
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    alu_port_a = '0;
    alu_port_b = '0;
    alu_aluop  = '0;
    can_accept = !wb_valid || wb_ready;
    if (req0_valid && req1_valid) begin
      grant0 = !rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
    // The ALU is driven even while stalled so the operands are visible early
    if (grant0) begin
      alu_port_a = req0_port_a;
      alu_port_b = req0_port_b;
      alu_aluop  = req0_aluop;
    end else if (grant1) begin
      alu_port_a = req1_port_a;
      alu_port_b = req1_port_b;
      alu_aluop  = req1_aluop;
    end
    req0_ready = grant0 && can_accept;
    req1_ready = grant1 && can_accept;
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    op_illegal = is_illegal(alu_aluop);
  end

  // Writeback register: refill on accept, otherwise drain on consumer ready
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid   <= 1'b0;
      wb_result  <= '0;
      wb_rd      <= '0;
      wb_src     <= 1'b0;
      wb_illegal <= 1'b0;
      rr_ptr     <= 1'b0;
    end else if (acc0 || acc1) begin
      wb_valid   <= 1'b1;
      wb_result  <= alu_out;
      wb_rd      <= acc1 ? req1_rd : req0_rd;
      wb_src     <= acc1;
      wb_illegal <= op_illegal;
      rr_ptr     <= acc0;
    end else if (wb_valid && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // Saturating per-requester accept counters for performance monitoring
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (acc0 && (grant_cnt0 != {CNT_W{1'b1}})) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (acc1 && (grant_cnt1 != {CNT_W{1'b1}})) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fu_alu_arbiter.sv
// tb/tb_fu_alu_arbiter.sv - self-checking bench for fu_alu_arbiter
module tb_fu_alu_arbiter;
  localparam int W = 32;
  localparam int T = 5;
  localparam int C = 4;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_port_a, req0_port_b, req1_port_a, req1_port_b;
  logic [3:0]   req0_aluop, req1_aluop, alu_aluop;
  logic [T-1:0] req0_rd, req1_rd, wb_rd;
  logic [W-1:0] alu_port_a, alu_port_b, alu_out, wb_result;
  logic         wb_valid, wb_ready, wb_src, wb_illegal;
  logic [C-1:0] grant_cnt0, grant_cnt1;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic         m_valid;
  logic [W-1:0] m_result;
  logic [T-1:0] m_rd;
  logic         m_src, m_ill;
  int           m_prio;
  int           m_n0, m_n1;

  fu_alu_arbiter #(.WORD_W(W), .TAG_W(T), .CNT_W(C)) dut (
    .CLK(CLK), .nRST(nRST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_port_a(req0_port_a),
    .req0_port_b(req0_port_b), .req0_aluop(req0_aluop), .req0_rd(req0_rd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_port_a(req1_port_a),
    .req1_port_b(req1_port_b), .req1_aluop(req1_aluop), .req1_rd(req1_rd),
    .alu_port_a(alu_port_a), .alu_port_b(alu_port_b), .alu_aluop(alu_aluop),
    .alu_out(alu_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_src(wb_src), .wb_illegal(wb_illegal),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
    case (op)
      4'd0:    alu_ref = a << b[4:0];
      4'd1:    alu_ref = a >> b[4:0];
      4'd2:    alu_ref = $signed(a) >>> b[4:0];
      4'd3:    alu_ref = a + b;
      4'd4:    alu_ref = a - b;
      4'd5:    alu_ref = a & b;
      4'd6:    alu_ref = a | b;
      4'd7:    alu_ref = a ^ b;
      4'd10:   alu_ref = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11:   alu_ref = (a < b) ? 32'd1 : 32'd0;
      default: alu_ref = a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic illegal_ref(input logic [3:0] op);
    illegal_ref = (op == 4'd8) || (op == 4'd9) || (op >= 4'd12);
  endfunction

  // Stand-in for the combinational fu_alu
  assign alu_out = alu_ref(alu_port_a, alu_port_b, alu_aluop);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] op, input logic [T-1:0] rd);
    req0_valid = v; req0_port_a = a; req0_port_b = b; req0_aluop = op; req0_rd = rd;
  endtask

  task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] op, input logic [T-1:0] rd);
    req1_valid = v; req1_port_a = a; req1_port_b = b; req1_aluop = op; req1_rd = rd;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_result = '0; m_rd = '0; m_src = 1'b0; m_ill = 1'b0;
    m_prio = 0; m_n0 = 0; m_n1 = 0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #12;
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // One clock: check handshake/ALU drive, take the edge, check the writeback state
  task automatic step();
    int           winner;
    logic         can;
    logic [W-1:0] ea, eb;
    logic [3:0]   eop;
    #1;
    can = !m_valid || wb_ready;
    if (req0_valid && req1_valid) winner = m_prio;
    else if (req0_valid)          winner = 0;
    else if (req1_valid)          winner = 1;
    else                          winner = -1;
    ea = '0; eb = '0; eop = '0;
    if (winner == 0) begin ea = req0_port_a; eb = req0_port_b; eop = req0_aluop; end
    if (winner == 1) begin ea = req1_port_a; eb = req1_port_b; eop = req1_aluop; end
    check("req0_ready", req0_ready, (winner == 0) && can);
    check("req1_ready", req1_ready, (winner == 1) && can);
    check("alu_port_a", alu_port_a, ea);
    check("alu_port_b", alu_port_b, eb);
    check("alu_aluop", alu_aluop, eop);
    @(posedge CLK);
    if (winner >= 0 && can) begin
      m_valid  = 1'b1;
      m_result = alu_ref(ea, eb, eop);
      m_rd     = (winner == 1) ? req1_rd : req0_rd;
      m_src    = (winner == 1);
      m_ill    = illegal_ref(eop);
      m_prio   = 1 - winner;
      if (winner == 0) m_n0++; else m_n1++;
    end else if (m_valid && wb_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("wb_valid", wb_valid, m_valid);
    check("wb_result", wb_result, m_result);
    check("wb_rd", wb_rd, m_rd);
    check("wb_src", wb_src, m_src);
    check("wb_illegal", wb_illegal, m_ill);
    check("grant_cnt0", grant_cnt0, (m_n0 > 15) ? 15 : m_n0);
    check("grant_cnt1", grant_cnt1, (m_n1 > 15) ? 15 : m_n1);
  endtask

  initial begin
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    wb_ready = 1'b0;
    model_reset();
    nRST = 1'b0;
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_cnt0", grant_cnt0, 0);
    do_reset();

    // Single requester SLL
    set0(1, 8, 1, 4'd0, 3);
    wb_ready = 1'b1;
    step();
    check("t1_result", wb_result, 16);
    check("t1_cnt0", grant_cnt0, 1);

    // Contested alternation
    do_reset();
    set0(1, 2, 3, 4'd3, 1);
    set1(1, 6, 2, 4'd4, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_src", wb_src, i % 2);
      check("t2_result", wb_result, (i % 2) ? 4 : 5);
    end
    check("t2_cnt0", grant_cnt0, 2);
    check("t2_cnt1", grant_cnt1, 2);

    // Stall, then drain with same-cycle refill
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_held", wb_result, 4);
    end
    wb_ready = 1'b1;
    step();
    check("t3_refill_src", wb_src, 0);

    // Drain and refill in one cycle with XOR
    set0(0, 0, 0, 0, 0);
    set1(1, 32'h0000FFFF, 32'h0000F0E0, 4'd7, 7);
    step();
    check("t4_result", wb_result, 32'h00000F1F);
    check("t4_valid", wb_valid, 1);
    check("t4_src", wb_src, 1);

    // Illegal and signed/unsigned compare
    set1(0, 0, 0, 0, 0);
    set0(1, 32'h1234, 32'h5678, 4'd9, 9);
    step();
    check("t5_illegal", wb_illegal, 1);
    set0(1, 32'h0000F0E0, 32'h0000FFE0, 4'd10, 10);
    step();
    check("t5_slt", wb_result, 1);
    set0(1, 32'hF000FFE0, 32'h0000F0E0, 4'd11, 11);
    step();
    check("t5_sltu", wb_result, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      set0($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
           4'($urandom_range(0, 15)), 5'($urandom));
      set1($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
           4'($urandom_range(0, 15)), 5'($urandom));
      wb_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset during a stall
    set0(1, 1, 1, 4'd3, 4);
    set1(1, 2, 2, 4'd3, 5);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    step();
    #3;
    nRST = 1'b0;
    #1;
    check("ar_wb_valid", wb_valid, 0);
    check("ar_wb_result", wb_result, 0);
    check("ar_wb_rd", wb_rd, 0);
    check("ar_wb_src", wb_src, 0);
    check("ar_wb_illegal", wb_illegal, 0);
    check("ar_cnt0", grant_cnt0, 0);
    check("ar_cnt1", grant_cnt1, 0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    wb_ready = 1'b1;
    #1;
    check("ar_first_grant", req0_ready, 1);
    step();
    check("ar_first_src", wb_src, 0);

    // Counter saturation
    set1(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt0", grant_cnt0, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
